// File: rtl/linear_layer_start_fifo_srl_ctrl.sv
// ============================================================================
// Module      : linear_layer_start_fifo_srl_ctrl
// Description : Shift-register start-token FIFO (FWFT) with registered
//               occupancy count, read pointer and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module linear_layer_start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    localparam logic [ADDR_WIDTH:0] C_DEPTH     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_DEPTH_M1  = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] C_CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] w_mem_d [DEPTH];

    logic [ADDR_WIDTH:0]   r_cnt_q;
    logic [ADDR_WIDTH:0]   w_cnt_d;
    logic [ADDR_WIDTH-1:0] r_raddr_q;
    logic [ADDR_WIDTH-1:0] w_raddr_d;
    logic                  r_empty_n_q;
    logic                  w_empty_n_d;
    logic                  r_full_n_q;
    logic                  w_full_n_d;

    logic w_push;
    logic w_pop;

    assign w_push = if_write & if_write_ce & r_full_n_q;
    assign w_pop  = if_read  & if_read_ce  & r_empty_n_q;

    // Every push shifts the whole array up by one; the oldest word therefore
    // always sits at index cnt-1, which is what the read pointer tracks.
    always_comb begin
        w_mem_d = r_mem_q;
        if (w_push) begin
            w_mem_d[0] = if_din;
            for (int i = 1; i < DEPTH; i++) begin
                w_mem_d[i] = r_mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    always_comb begin
        w_cnt_d     = r_cnt_q;
        w_raddr_d   = r_raddr_q;
        w_empty_n_d = r_empty_n_q;
        w_full_n_d  = r_full_n_q;
        if (w_push && !w_pop) begin
            w_cnt_d     = r_cnt_q + C_CNT_ONE;
            w_empty_n_d = 1'b1;
            if (r_cnt_q != '0) begin
                w_raddr_d = r_raddr_q + C_PTR_ONE;
            end
            if (r_cnt_q == C_DEPTH_M1) begin
                w_full_n_d = 1'b0;
            end
        end else if (w_pop && !w_push) begin
            w_cnt_d    = r_cnt_q - C_CNT_ONE;
            w_full_n_d = 1'b1;
            if (r_cnt_q > C_CNT_ONE) begin
                w_raddr_d = r_raddr_q - C_PTR_ONE;
            end
            if (r_cnt_q == C_CNT_ONE) begin
                w_empty_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_q     <= '0;
            r_raddr_q   <= '0;
            r_empty_n_q <= 1'b0;
            r_full_n_q  <= 1'b1;
        end else begin
            r_cnt_q     <= w_cnt_d;
            r_raddr_q   <= w_raddr_d;
            r_empty_n_q <= w_empty_n_d;
            r_full_n_q  <= w_full_n_d;
        end
    end

    assign if_dout           = r_mem_q[r_raddr_q];
    assign if_empty_n        = r_empty_n_q;
    assign if_full_n         = r_full_n_q;
    assign if_num_data_valid = r_cnt_q;
    assign if_fifo_cap       = C_DEPTH;

endmodule

`default_nettype wire

// File: tb/tb_linear_layer_start_fifo_srl_ctrl.sv
// ============================================================================
// Module      : tb_linear_layer_start_fifo_srl_ctrl
// Description : Directed, scoreboard-based bench for the start-token FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_linear_layer_start_fifo_srl_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset_n;
    logic          if_full_n;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_empty_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic [AW:0]   if_num_data_valid;
    logic [AW:0]   if_fifo_cap;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb [$];
    int            exp_cnt = 0;

    linear_layer_start_fifo_srl_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_full_n        (if_full_n),
        .if_write_ce      (if_write_ce),
        .if_write         (if_write),
        .if_din           (if_din),
        .if_empty_n       (if_empty_n),
        .if_read_ce       (if_read_ce),
        .if_read          (if_read),
        .if_dout          (if_dout),
        .if_num_data_valid(if_num_data_valid),
        .if_fifo_cap      (if_fifo_cap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_cnt"},     32'(if_num_data_valid), 32'(exp_cnt));
        chk({tag, "_empty_n"}, 32'(if_empty_n),        32'(exp_cnt != 0));
        chk({tag, "_full_n"},  32'(if_full_n),         32'(exp_cnt != DEPTH));
        if (exp_cnt != 0) begin
            chk({tag, "_dout"}, 32'(if_dout), 32'(sb[0]));
        end
    endtask

    // One clock: drive request, model the handshake, check the popped word
    // before the edge and the resulting state after it.
    task automatic cycle(input string tag, input logic wr, input logic wce,
                         input logic [DW-1:0] din, input logic rd, input logic rce);
        logic push;
        logic pop;
        push        = wr & wce & (exp_cnt != DEPTH);
        pop         = rd & rce & (exp_cnt != 0);
        if_write    = wr;
        if_write_ce = wce;
        if_din      = din;
        if_read     = rd;
        if_read_ce  = rce;
        if (pop) begin
            chk({tag, "_pop_data"}, 32'(if_dout), 32'(sb[0]));
            void'(sb.pop_front());
        end
        if (push) sb.push_back(din);
        exp_cnt = exp_cnt + int'(push) - int'(pop);
        @(posedge clk);
        #1;
        if_write    = 1'b0;
        if_write_ce = 1'b0;
        if_read     = 1'b0;
        if_read_ce  = 1'b0;
        chk_state(tag);
    endtask

    initial begin
        reset_n     = 1'b0;
        if_write    = 1'b0;
        if_write_ce = 1'b0;
        if_din      = '0;
        if_read     = 1'b0;
        if_read_ce  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // reset / idle
        chk_state("reset");
        chk("fifo_cap", 32'(if_fifo_cap), 32'(DEPTH));
        cycle("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // fill to full
        cycle("fill1", 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        cycle("fill2", 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        cycle("fill3", 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        cycle("fill4", 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);

        // write while full ignored, then drain
        cycle("wr_full", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle("drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        end

        // simultaneous push/pop at cnt=1
        cycle("seed", 1'b1, 1'b1, 8'hA0, 1'b0, 1'b0);
        cycle("pp_b0", 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle("stream", 1'b1, 1'b1, 8'(8'hC0 + i), 1'b1, 1'b1);
        end
        // simultaneous push/pop at cnt=3
        cycle("grow1", 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        cycle("grow2", 1'b1, 1'b1, 8'h5B, 1'b0, 1'b0);
        cycle("pp_cnt3", 1'b1, 1'b1, 8'h5C, 1'b1, 1'b1);
        cycle("shrink1", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // clock enables low while requesting at cnt=2
        cycle("ce_off", 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
        cycle("drain_a", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle("drain_b", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle("pop_empty", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // asynchronous reset mid-cycle at cnt=3
        cycle("pre_rst1", 1'b1, 1'b1, 8'h61, 1'b0, 1'b0);
        cycle("pre_rst2", 1'b1, 1'b1, 8'h62, 1'b0, 1'b0);
        cycle("pre_rst3", 1'b1, 1'b1, 8'h63, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt = 0;
        chk_state("async_rst");
        #1;
        reset_n = 1'b1;
        cycle("post_rst", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst_dout", 32'(if_dout), 32'h77);
        cycle("post_rst_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
